cia_bus_slave: RTL and testbench

CIA_BUS_SLAVE -- requirements
Module: cia_bus_slave

---
 rtl/cia_bus_slave.sv | 102 ++++++++++
 tb/tb_cia_bus_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cia_bus_slave.sv
// CIA-style register bus slave: decodes E-clock bus cycles into one-clk
// read/write strobes toward a register file and drives read data back to the bus.
module cia_bus_slave #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              _reset_in,
   input  logic              reg_decode,
   input  logic              _cs,
   input  logic              e,
   input  logic              r_w,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data_in,
   input  logic [7:0]        rd_data,
   output logic              rd_strobe,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        wr_data,
   output logic [7:0]        data_out,
   output logic              data_oe
);

   typedef enum logic [1:0] {IDLE, START, ACCESS, HOLD} state_t;

   state_t state, state_nxt;
   logic   e_d;
   logic   e_qual;
   logic   dir;
   logic   rd_ack;
   logic   e_rise, e_fall;
   logic   start_acc;
   logic   wr_commit;

   // e_qual keeps a stale e_d from faking an edge on the first clk after reset
   assign e_rise = e & ~e_d & e_qual;
   assign e_fall = ~e & e_d & e_qual;

   always_ff @(posedge clk or negedge _reset_in) begin
      if (!_reset_in) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      wr_commit = 1'b0;
      case (state)
         IDLE: begin
            if (e_rise && !_cs && reg_decode) begin
               start_acc = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            state_nxt = _cs ? IDLE : ACCESS;
         end
         ACCESS: begin
            // chip-select release wins over a coincident E edge
            if (_cs) begin
               state_nxt = IDLE;
            end else if (e_fall) begin
               wr_commit = ~dir;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (_cs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge _reset_in) begin
      if (!_reset_in) begin
         e_d       <= 1'b0;
         e_qual    <= 1'b0;
         dir       <= 1'b1;
         rd_strobe <= 1'b0;
         wr_strobe <= 1'b0;
         rd_ack    <= 1'b0;
         reg_addr  <= '0;
         wr_data   <= 8'h00;
         data_out  <= 8'h00;
         data_oe   <= 1'b0;
      end else begin
         e_d       <= e;
         e_qual    <= 1'b1;
         rd_strobe <= start_acc & r_w;
         wr_strobe <= wr_commit;
         rd_ack    <= rd_strobe;
         if (start_acc) begin
            reg_addr <= addr;
            dir      <= r_w;
         end
         if (wr_commit) wr_data <= data_in;
         // register file answers one clk after the strobe, i.e. during the first ACCESS clk
         if (state == ACCESS && rd_ack && dir) data_out <= rd_data;
         data_oe <= dir && (state_nxt == ACCESS || state_nxt == HOLD);
      end
   end

endmodule

// File: tb/tb_cia_bus_slave.sv
// Bench for cia_bus_slave: directed bus cycles plus randomized cycles checked
// against a transaction-level model of the register file and strobe counts.
module tb_cia_bus_slave;

   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              _reset_in;
   logic              reg_decode;
   logic              _cs;
   logic              e;
   logic              r_w;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data_in;
   logic [7:0]        rd_data;
   logic              rd_strobe;
   logic              wr_strobe;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        wr_data;
   logic [7:0]        data_out;
   logic              data_oe;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cia_bus_slave #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      ._reset_in  (_reset_in),
      .reg_decode (reg_decode),
      ._cs        (_cs),
      .e          (e),
      .r_w        (r_w),
      .addr       (addr),
      .data_in    (data_in),
      .rd_data    (rd_data),
      .rd_strobe  (rd_strobe),
      .wr_strobe  (wr_strobe),
      .reg_addr   (reg_addr),
      .wr_data    (wr_data),
      .data_out   (data_out),
      .data_oe    (data_oe)
   );

   // Register file attached to the slave
   logic [7:0] seed_mem [16];
   logic [7:0] regs     [16];
   logic       load_regs;

   always @(posedge clk) begin
      if (load_regs) begin
         for (int i = 0; i < 16; i++) regs[i] <= seed_mem[i];
      end else begin
         if (rd_strobe) rd_data <= regs[reg_addr];
         if (wr_strobe) regs[reg_addr] <= wr_data;
      end
   end

   // Strobe monitor, sampled just after each active edge
   int         rd_cnt = 0;
   int         wr_cnt = 0;
   int         both_cnt = 0;
   logic [3:0] rd_addr_log = '0;
   logic [3:0] wr_addr_log = '0;
   logic [7:0] wr_data_log = '0;

   always @(posedge clk) begin
      #1;
      if (rd_strobe) begin
         rd_cnt      <= rd_cnt + 1;
         rd_addr_log <= reg_addr;
      end
      if (wr_strobe) begin
         wr_cnt      <= wr_cnt + 1;
         wr_addr_log <= reg_addr;
         wr_data_log <= wr_data;
      end
      if (rd_strobe && wr_strobe) both_cnt <= both_cnt + 1;
   end

   // Reference model: register contents as the CPU should see them
   logic [7:0] ref_mem [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One complete CIA bus cycle, checked against the model
   task automatic bus_cycle(input logic rw, input logic [3:0] a, input logic [7:0] d,
                            input logic dec, input logic abort);
      int   exp_rd;
      int   exp_wr;
      logic is_rd;
      logic is_wr;
      is_rd  = dec && rw;
      is_wr  = dec && !rw && !abort;
      exp_rd = rd_cnt + (is_rd ? 1 : 0);
      exp_wr = wr_cnt + (is_wr ? 1 : 0);
      addr = a; r_w = rw; reg_decode = dec; data_in = ~d; _cs = 1'b0;
      step(2);
      e = 1'b1;
      step(6);
      chk("oe_e_high", data_oe, is_rd);
      if (is_rd) chk("dout_e_high", data_out, ref_mem[a]);
      if (abort) begin
         _cs = 1'b1;
         step(2);
         chk("oe_abort", data_oe, 1'b0);
         e = 1'b0;
         step(3);
      end else begin
         data_in = d;
         e = 1'b0;
         step(3);
         if (is_wr) ref_mem[a] = d;
         chk("oe_hold", data_oe, is_rd);
         if (is_rd) chk("dout_hold", data_out, ref_mem[a]);
         _cs = 1'b1;
         step(3);
         chk("oe_release", data_oe, 1'b0);
      end
      chk("rd_count", rd_cnt, exp_rd);
      chk("wr_count", wr_cnt, exp_wr);
      if (is_wr) begin
         chk("wr_data", wr_data_log, d);
         chk("wr_addr", wr_addr_log, a);
      end
      if (is_rd) chk("rd_addr", rd_addr_log, a);
   endtask

   initial begin
      int         base_rd;
      int         base_wr;
      logic [7:0] wd_before;
      for (int i = 0; i < 16; i++) begin
         seed_mem[i] = 8'($urandom);
      end
      seed_mem[5] = 8'hA7;
      for (int i = 0; i < 16; i++) ref_mem[i] = seed_mem[i];

      _reset_in = 1'b0; load_regs = 1'b1;
      reg_decode = 1'b0; _cs = 1'b1; e = 1'b0; r_w = 1'b1;
      addr = '0; data_in = 8'h00;
      step(3);
      chk("rst_rd_strobe", rd_strobe, 1'b0);
      chk("rst_wr_strobe", wr_strobe, 1'b0);
      chk("rst_data_oe",   data_oe,   1'b0);
      chk("rst_data_out",  data_out,  8'h00);
      chk("rst_wr_data",   wr_data,   8'h00);
      chk("rst_reg_addr",  reg_addr,  4'h0);
      _reset_in = 1'b1; load_regs = 1'b0;
      step(2);

      // Read of 0x5: strobe during START, oe from first ACCESS clk, data one clk later
      addr = 4'h5; r_w = 1'b1; reg_decode = 1'b1; _cs = 1'b0;
      step(2);
      e = 1'b1;
      step(1);
      chk("rd34_strobe_on", rd_strobe, 1'b1);
      chk("rd34_addr", reg_addr, 4'h5);
      chk("rd34_oe_early", data_oe, 1'b0);
      step(1);
      chk("rd34_strobe_off", rd_strobe, 1'b0);
      chk("rd34_oe_on", data_oe, 1'b1);
      step(1);
      chk("rd34_dout", data_out, 8'hA7);
      step(2);
      e = 1'b0;
      step(2);
      // HOLD ignores a fresh E rise while _cs stays low
      e = 1'b1;
      step(3);
      chk("hold_no_restart", rd_cnt, 1);
      chk("rd34_oe_held", data_oe, 1'b1);
      chk("rd34_dout_held", data_out, 8'hA7);
      _cs = 1'b1;
      step(1);
      chk("rd34_oe_drop", data_oe, 1'b0);
      e = 1'b0;
      step(3);

      // Write 0x3C to 0xC
      base_wr = wr_cnt;
      addr = 4'hC; r_w = 1'b0; _cs = 1'b0; data_in = 8'h00;
      step(2);
      e = 1'b1;
      step(4);
      chk("wr35_oe_access", data_oe, 1'b0);
      chk("wr35_no_early", wr_strobe, 1'b0);
      data_in = 8'h3C;
      e = 1'b0;
      step(1);
      chk("wr35_strobe_on", wr_strobe, 1'b1);
      chk("wr35_data", wr_data, 8'h3C);
      chk("wr35_addr", reg_addr, 4'hC);
      step(1);
      chk("wr35_strobe_off", wr_strobe, 1'b0);
      chk("wr35_oe_hold", data_oe, 1'b0);
      _cs = 1'b1;
      step(3);
      chk("wr35_count", wr_cnt, base_wr + 1);
      ref_mem[12] = 8'h3C;

      // Aborted write leaves wr_data alone
      wd_before = wr_data;
      bus_cycle(1'b0, 4'h7, 8'h99, 1'b1, 1'b1);
      chk("abort_wr_data", wr_data, wd_before);

      // Foreign select
      bus_cycle(1'b1, 4'h3, 8'h00, 1'b0, 1'b0);
      bus_cycle(1'b0, 4'h3, 8'h55, 1'b0, 1'b0);

      // Back-to-back reads
      bus_cycle(1'b1, 4'h1, 8'h00, 1'b1, 1'b0);
      bus_cycle(1'b1, 4'h2, 8'h00, 1'b1, 1'b0);
      bus_cycle(1'b1, 4'hC, 8'h00, 1'b1, 1'b0);

      // Reset in the middle of a read
      base_rd = rd_cnt;
      addr = 4'h5; r_w = 1'b1; reg_decode = 1'b1; _cs = 1'b0;
      step(2);
      e = 1'b1;
      step(4);
      chk("rstmid_oe_before", data_oe, 1'b1);
      #2 _reset_in = 1'b0;
      #1;
      chk("rstmid_oe_async", data_oe, 1'b0);
      chk("rstmid_dout_async", data_out, 8'h00);
      step(2);
      _reset_in = 1'b1;
      step(4);
      chk("rstmid_no_strobe", rd_cnt, base_rd + 1);
      e = 1'b0;
      step(2);
      e = 1'b1;
      step(1);
      chk("rstmid_new_rise", rd_strobe, 1'b1);
      step(3);
      chk("rstmid_new_dout", data_out, ref_mem[5]);
      e = 1'b0;
      _cs = 1'b1;
      step(3);
      chk("rstmid_count", rd_cnt, base_rd + 2);

      // Randomized cycles
      for (int k = 0; k < 24; k++) begin
         bus_cycle(1'($urandom), 4'($urandom), 8'($urandom),
                   ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0));
      end

      chk("no_dual_strobe", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
